// File: rtl/urv_mem_arbiter.sv
// Purpose: shares one synchronous single-port RAM between uRV fetch and data ports, plus a byte-wide IO register.
// Latency: every accepted fetch/data op (RAM, IO or unmapped) responds with a one-cycle pulse in the next cycle.
// Backpressure: one data op in flight (dm_ready_o low during its response cycle); fetch is re-requested each cycle.
// Option: define URV_ARB_FAIR_EN to alternate grants on fetch/data contention (default: fixed data priority).
module urv_mem_arbiter #(
  parameter int          ADDR_BITS = 16,
  parameter logic [31:0] IO_ADDR   = 32'h0001_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          im_addr_i,
  input  logic                 im_rd_i,
  output logic [31:0]          im_data_o,
  output logic                 im_valid_o,
  input  logic [31:0]          dm_addr_i,
  input  logic [31:0]          dm_data_s_i,
  input  logic [3:0]           dm_data_select_i,
  input  logic                 dm_store_i,
  input  logic                 dm_load_i,
  output logic [31:0]          dm_data_l_o,
  output logic                 dm_load_done_o,
  output logic                 dm_store_done_o,
  output logic                 dm_ready_o,
  output logic [ADDR_BITS-3:0] ram_addr_o,
  output logic [31:0]          ram_data_o,
  output logic [3:0]           ram_be_o,
  output logic                 ram_we_o,
  input  logic [31:0]          ram_data_i,
  output logic [7:0]           io_o
);

  typedef enum logic {IDLE, DATA_PEND} state_t;

  state_t      state, state_nxt;
  logic        dm_req, dm_ram, dm_io;
  logic        accept, contention, grant_data, grant_fetch;
  logic        favor_fetch;
  logic        fetch_vld, load_done, store_done, pend_ram;
  logic [31:0] im_data_q, dm_data_q;
  logic        unused_addr_bits;

  // Fetch addresses are word aligned and only the RAM window is decoded.
  assign unused_addr_bits = ^{im_addr_i[31:ADDR_BITS], im_addr_i[1:0]};

  // A simultaneous load and store is served as a store.
  assign dm_req = dm_load_i | dm_store_i;
  assign dm_ram = (dm_addr_i[31:16] == 16'h0000);
  assign dm_io  = (dm_addr_i == IO_ADDR);

  // Arbitration and in-flight tracking; only RAM data ops compete with fetch for the port.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    contention  = 1'b0;
    grant_data  = 1'b0;
    case (state)
      IDLE: begin
        contention = dm_req && dm_ram && im_rd_i;
        grant_data = dm_req && dm_ram && !(contention && favor_fetch);
        accept     = dm_req && (!dm_ram || grant_data);
        if (accept) state_nxt = DATA_PEND;
      end
      DATA_PEND: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign grant_fetch = im_rd_i && !grant_data;

  // RAM port driven straight from the grant; writes are suppressed while in reset.
  assign ram_addr_o = grant_data ? dm_addr_i[ADDR_BITS-1:2] : im_addr_i[ADDR_BITS-1:2];
  assign ram_we_o   = grant_data && dm_store_i && !rst_i;
  assign ram_be_o   = (grant_data && dm_store_i) ? dm_data_select_i : 4'b0000;
  assign ram_data_o = dm_data_s_i;

`ifdef URV_ARB_FAIR_EN
  // Remember the contention winner so the other requester wins next time.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           favor_fetch <= 1'b0;
    else if (contention) favor_fetch <= grant_data;
  end
`else
  assign favor_fetch = 1'b0;
`endif

  // Data op state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Response pulses for the cycle after a grant/accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_vld  <= 1'b0;
      load_done  <= 1'b0;
      store_done <= 1'b0;
      pend_ram   <= 1'b0;
    end else begin
      fetch_vld  <= grant_fetch;
      load_done  <= accept && !dm_store_i;
      store_done <= accept && dm_store_i;
      pend_ram   <= accept && dm_ram;
    end
  end

  // Byte-wide output register; an IO store never occupies the RAM slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      io_o <= 8'h00;
    else if (accept && dm_store_i && dm_io && !dm_ram && dm_data_select_i[0])
      io_o <= dm_data_s_i[7:0];
  end

  // Hold the last returned fetch/load words between response cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      im_data_q <= 32'h0;
      dm_data_q <= 32'h0;
    end else begin
      if (fetch_vld) im_data_q <= ram_data_i;
      if (load_done) dm_data_q <= dm_data_l_o;
    end
  end

  // IO and unmapped loads return zero.
  assign im_data_o       = fetch_vld ? ram_data_i : im_data_q;
  assign dm_data_l_o     = load_done ? (pend_ram ? ram_data_i : 32'h0) : dm_data_q;
  assign im_valid_o      = fetch_vld;
  assign dm_load_done_o  = load_done;
  assign dm_store_done_o = store_done;
  assign dm_ready_o      = (state == IDLE);

endmodule

// File: tb/tb_urv_mem_arbiter.sv
// Directed bench for urv_mem_arbiter with a behavioural synchronous RAM.
// Expected responses are queued when a cycle's stimulus is driven and checked in the following cycle.
// Contention expectations follow URV_ARB_FAIR_EN when it is defined.
module tb_urv_mem_arbiter;

  localparam logic [31:0] IO_ADDR = 32'h0001_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] im_addr_i;
  logic        im_rd_i;
  logic [31:0] im_data_o;
  logic        im_valid_o;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_store_i;
  logic        dm_load_i;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o;
  logic        dm_store_done_o;
  logic        dm_ready_o;
  logic [13:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic [3:0]  ram_be_o;
  logic        ram_we_o;
  logic [31:0] ram_data_i;
  logic [7:0]  io_o;

  urv_mem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .im_addr_i(im_addr_i), .im_rd_i(im_rd_i), .im_data_o(im_data_o), .im_valid_o(im_valid_o),
    .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i), .dm_data_select_i(dm_data_select_i),
    .dm_store_i(dm_store_i), .dm_load_i(dm_load_i), .dm_data_l_o(dm_data_l_o),
    .dm_load_done_o(dm_load_done_o), .dm_store_done_o(dm_store_done_o), .dm_ready_o(dm_ready_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_be_o(ram_be_o), .ram_we_o(ram_we_o),
    .ram_data_i(ram_data_i), .io_o(io_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural RAM: one-cycle synchronous read, byte-enabled write.
  logic [31:0] mem [0:16383];
  always @(posedge clk_i) begin
    ram_data_i <= mem[ram_addr_o];
    if (ram_we_o)
      for (int b = 0; b < 4; b++)
        if (ram_be_o[b]) mem[ram_addr_o][8*b +: 8] = ram_data_o[8*b +: 8];
  end

  typedef struct {
    logic        fv;
    logic [31:0] fd;
    logic        lv;
    logic [31:0] ld;
    logic        sv;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_im = 32'h0;
  logic [31:0] last_ld = 32'h0;

  function automatic logic [31:0] f(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic ird, input logic [31:0] ia, input logic ld, input logic st,
                     input logic [31:0] da, input logic [31:0] sd, input logic [3:0] sel);
    im_rd_i          = ird;
    im_addr_i        = ia;
    dm_load_i        = ld;
    dm_store_i       = st;
    dm_addr_i        = da;
    dm_data_s_i      = sd;
    dm_data_select_i = sel;
  endtask

  task automatic idle();
    drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic push(input logic fv, input logic [31:0] fd, input logic lv,
                      input logic [31:0] ld, input logic sv);
    exp_t e;
    e.fv = fv; e.fd = fd; e.lv = lv; e.ld = ld; e.sv = sv;
    sb.push_back(e);
  endtask

  // Advance one cycle and compare the response cycle against the oldest expectation.
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk_i);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_im_valid"}, 32'(im_valid_o), 32'(e.fv));
      if (e.fv) last_im = e.fd;
      chk({tag, "_im_data"}, im_data_o, last_im);
      chk({tag, "_load_done"}, 32'(dm_load_done_o), 32'(e.lv));
      if (e.lv) last_ld = e.ld;
      chk({tag, "_load_data"}, dm_data_l_o, last_ld);
      chk({tag, "_store_done"}, 32'(dm_store_done_o), 32'(e.sv));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit lv;
    for (int i = 0; i < 16384; i++) mem[i] = f(i);

    // Reset state, including a write request presented during reset.
    rst_i = 1'b1;
    drv(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h1111_1111, 4'hF);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    chk("rst_ram_we", 32'(ram_we_o), 32'h0);
    chk("rst_im_valid", 32'(im_valid_o), 32'h0);
    chk("rst_load_done", 32'(dm_load_done_o), 32'h0);
    chk("rst_store_done", 32'(dm_store_done_o), 32'h0);
    chk("rst_ready", 32'(dm_ready_o), 32'h1);
    chk("rst_io", 32'(io_o), 32'h0);
    chk("rst_load_data", dm_data_l_o, 32'h0);
    chk("rst_im_data", im_data_o, 32'h0);
    idle();
    rst_i = 1'b0;

    // Fetch-only stream: words 0,1,2 back to back.
    drv(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1 chk("fetch_first_invalid", 32'(im_valid_o), 32'h0);
    push(1'b1, f(0), 1'b0, 32'h0, 1'b0); tick("fetch0");
    drv(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    push(1'b1, f(1), 1'b0, 32'h0, 1'b0); tick("fetch1");
    drv(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    push(1'b1, f(2), 1'b0, 32'h0, 1'b0); tick("fetch2");

    // RAM store contends with fetch: data wins, fetch stalls one cycle.
    drv(1'b1, 32'hC, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0011);
    #1;
    chk("st_ram_we", 32'(ram_we_o), 32'h1);
    chk("st_ram_be", 32'(ram_be_o), 32'h3);
    chk("st_ram_addr", 32'(ram_addr_o), 32'h4);
    chk("st_ram_data", ram_data_o, 32'hDEAD_BEEF);
    push(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); tick("st_ram");
    chk("st_pend_ready", 32'(dm_ready_o), 32'h0);
    drv(1'b1, 32'hC, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0011);
    #1 chk("st_pend_we", 32'(ram_we_o), 32'h0);
    push(1'b1, f(3), 1'b0, 32'h0, 1'b0); tick("st_pend");
    drv(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    push(1'b1, 32'hC0DE_BEEF, 1'b0, 32'h0, 1'b0); tick("st_verify");
    idle();
    push(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); tick("idle_hold");
    rst_i = 1'b1;
    #1 rst_i = 1'b0;
    last_im = 32'h0;

    // RAM load of the stored word while fetching.
    drv(1'b1, 32'h14, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    push(1'b0, 32'h0, 1'b1, 32'hC0DE_BEEF, 1'b0); tick("ld_ram");
    chk("ld_pend_ready", 32'(dm_ready_o), 32'h0);
    drv(1'b1, 32'h14, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    push(1'b1, f(5), 1'b0, 32'h0, 1'b0); tick("ld_pend");

    // IO store does not take the RAM slot.
    drv(1'b1, 32'h18, 1'b0, 1'b1, IO_ADDR, 32'h41, 4'b0001);
    #1;
    chk("io_st_ram_we", 32'(ram_we_o), 32'h0);
    chk("io_st_ram_addr", 32'(ram_addr_o), 32'h6);
    push(1'b1, f(6), 1'b0, 32'h0, 1'b1); tick("io_st");
    chk("io_reg", 32'(io_o), 32'h41);
    drv(1'b1, 32'h1C, 1'b0, 1'b1, IO_ADDR, 32'h41, 4'b0001);
    push(1'b1, f(7), 1'b0, 32'h0, 1'b0); tick("io_st_pend");

    // Unmapped load returns zero.
    drv(1'b1, 32'h20, 1'b1, 1'b0, 32'h0002_0000, 32'h0, 4'h0);
    push(1'b1, f(8), 1'b1, 32'h0, 1'b0); tick("unm_ld");
    drv(1'b1, 32'h20, 1'b1, 1'b0, 32'h0002_0000, 32'h0, 4'h0);
    push(1'b1, f(8), 1'b0, 32'h0, 1'b0); tick("unm_ld_pend");

    // IO store without byte 0 enabled leaves the register unchanged.
    drv(1'b0, 32'h0, 1'b0, 1'b1, IO_ADDR, 32'h99, 4'b1110);
    push(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); tick("io_st_nobe");
    push(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); tick("io_st_nobe_pend");
    chk("io_reg_kept", 32'(io_o), 32'h41);

    // Unmapped store is dropped but still acknowledged.
    drv(1'b0, 32'h0, 1'b0, 1'b1, 32'h0003_0000, 32'h55, 4'hF);
    #1 chk("unm_st_ram_we", 32'(ram_we_o), 32'h0);
    push(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); tick("unm_st");
    push(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); tick("unm_st_pend");

    // Load and store together: served as a store only.
    drv(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 4'hF);
    #1 chk("ldst_ram_we", 32'(ram_we_o), 32'h1);
    push(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); tick("ldst");
    push(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); tick("ldst_pend");
    drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    push(1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b0); tick("ldst_verify");
    push(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); tick("ldst_verify_pend");

    // IO load returns zero after a nonzero load.
    drv(1'b0, 32'h0, 1'b1, 1'b0, IO_ADDR, 32'h0, 4'h0);
    push(1'b0, 32'h0, 1'b1, 32'h0, 1'b0); tick("io_ld");
    push(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); tick("io_ld_pend");

    // Reset asserted mid-cycle while a RAM load is pending.
    drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    push(1'b0, 32'h0, 1'b1, f(0), 1'b0); tick("rst_pend_ld");
    #2 rst_i = 1'b1;
    #1;
    chk("arst_ready", 32'(dm_ready_o), 32'h1);
    chk("arst_load_done", 32'(dm_load_done_o), 32'h0);
    chk("arst_load_data", dm_data_l_o, 32'h0);
    chk("arst_im_data", im_data_o, 32'h0);
    chk("arst_im_valid", 32'(im_valid_o), 32'h0);
    chk("arst_io", 32'(io_o), 32'h0);
    chk("arst_ram_we", 32'(ram_we_o), 32'h0);
    last_im = 32'h0;
    last_ld = 32'h0;
    @(posedge clk_i);
    #1;
    idle();
    rst_i = 1'b0;
    push(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); tick("post_rst0");
    push(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); tick("post_rst1");

    // Continuous fetch/data contention.
    drv(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 0; k < 8; k++) begin
`ifdef URV_ARB_FAIR_EN
      lv = (k % 3 == 0);
`else
      lv = (k % 2 == 0);
`endif
      push(!lv, f(1), lv, f(0), 1'b0);
      tick("contend");
    end
    idle();
    push(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); tick("contend_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
